// File: rtl/seq_scan_pkg.sv
// Shared types, default sizes and pattern-length helpers for the word-level sequence scanner.
package seq_scan_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int PAT_W_MAX_DEF = 8;
   localparam int CNT_W_DEF     = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } state_t;

   // A zero length still means "match a single bit"; oversize lengths saturate.
   function automatic int unsigned norm_len(input int unsigned len, input int unsigned max_len);
      if (len == 0) return 1;
      if (len > max_len) return max_len;
      return len;
   endfunction

   function automatic logic [31:0] len_mask(input int unsigned len);
      if (len >= 32) return '1;
      return (32'd1 << len) - 32'd1;
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial pattern matcher: history shift register, seen-counter and masked compare.
// match_o is combinational for the bit presented this cycle; state advances on shift_en_i.
module seq_match_core
   import seq_scan_pkg::*;
#(
   parameter int PAT_W_MAX = PAT_W_MAX_DEF,
   parameter int LEN_W     = $clog2(PAT_W_MAX + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic                 shift_en_i,
   input  logic                 bit_i,
   input  logic [PAT_W_MAX-1:0] pat_i,
   input  logic [LEN_W-1:0]     len_i,
   input  logic                 overlap_i,
   output logic                 match_o
);

   logic [PAT_W_MAX-1:0] hist_q, hist_d, hist_next;
   logic [LEN_W-1:0]     seen_q, seen_d, seen_next;
   logic [31:0]          mask;

   always_comb begin
      hist_next = (hist_q << 1) | PAT_W_MAX'(bit_i);
      seen_next = (seen_q >= LEN_W'(PAT_W_MAX)) ? seen_q : seen_q + 1'b1;
      mask      = len_mask(32'(len_i));
      match_o   = shift_en_i && (seen_next >= len_i) &&
                  (((32'(hist_next) ^ 32'(pat_i)) & mask) == 32'd0);

      hist_d = hist_q;
      seen_d = seen_q;
      if (clear_i) begin
         hist_d = '0;
         seen_d = '0;
      end else if (shift_en_i) begin
         hist_d = hist_next;
         // Non-overlapping mode forgets the bits of a completed hit, history stays.
         seen_d = (match_o && !overlap_i) ? '0 : seen_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
         seen_q <= '0;
      end else begin
         hist_q <= hist_d;
         seen_q <= seen_d;
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-in / count-out sequence scanner: accept, shift DATA_W bits MSB-first, report.
// out_valid rises DATA_W+1 edges after accept and holds until out_ready; in_ready only in IDLE.
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int  DATA_W    = DATA_W_DEF,
   parameter int  PAT_W_MAX = PAT_W_MAX_DEF,
   parameter int  CNT_W     = CNT_W_DEF,
   localparam int LEN_W     = $clog2(PAT_W_MAX + 1),
   localparam int POS_W     = $clog2(DATA_W)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PAT_W_MAX-1:0] cfg_pat,
   input  logic [LEN_W-1:0]     cfg_len,
   input  logic                 cfg_overlap,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_W-1:0]     out_count,
   output logic [POS_W-1:0]     out_last_pos,
   output logic                 hit,
   output logic                 busy
);

   state_t               state_q, state_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [PAT_W_MAX-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 ovl_q, ovl_d;
   logic [POS_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [POS_W-1:0]     last_pos_q, last_pos_d;
   logic                 hit_q, hit_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;
   logic                 busy_q, busy_d;
   logic                 core_clear, shift_en, match;

   seq_match_core #(
      .PAT_W_MAX (PAT_W_MAX),
      .LEN_W     (LEN_W)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (core_clear),
      .shift_en_i (shift_en),
      .bit_i      (data_q[DATA_W-1]),
      .pat_i      (pat_q),
      .len_i      (len_q),
      .overlap_i  (ovl_q),
      .match_o    (match)
   );

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      pat_d      = pat_q;
      len_d      = len_q;
      ovl_d      = ovl_q;
      idx_d      = idx_q;
      count_d    = count_q;
      last_pos_d = last_pos_q;
      hit_d      = 1'b0;
      core_clear = 1'b0;
      shift_en   = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d     = in_data;
               pat_d      = cfg_pat;
               len_d      = LEN_W'(norm_len(32'(cfg_len), PAT_W_MAX));
               ovl_d      = cfg_overlap;
               idx_d      = '0;
               count_d    = '0;
               last_pos_d = '0;
               core_clear = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            data_d   = data_q << 1;
            idx_d    = idx_q + 1'b1;
            if (match) begin
               hit_d      = 1'b1;
               count_d    = (&count_q) ? count_q : count_q + 1'b1;
               last_pos_d = idx_q;
            end
            if (idx_q == POS_W'(DATA_W - 1)) state_d = REPORT;
         end
         REPORT: begin
            if (out_valid_q && out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The first REPORT cycle is spent registering out_valid, so a stray out_ready is ignored.
      out_valid_d = (state_q == REPORT) && (state_d == REPORT);
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         pat_q       <= '0;
         len_q       <= '0;
         ovl_q       <= 1'b0;
         idx_q       <= '0;
         count_q     <= '0;
         last_pos_q  <= '0;
         hit_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         pat_q       <= pat_d;
         len_q       <= len_d;
         ovl_q       <= ovl_d;
         idx_q       <= idx_d;
         count_q     <= count_d;
         last_pos_q  <= last_pos_d;
         hit_q       <= hit_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_count    = count_q;
   assign out_last_pos = last_pos_q;
   assign hit          = hit_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl (DATA_W=16, PAT_W_MAX=8, CNT_W=3 so saturation is reachable).
module tb_seq_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cfg_pat = '0;
   logic [3:0]  cfg_len = '0;
   logic        cfg_overlap = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  out_count;
   logic [3:0]  out_last_pos;
   logic        hit;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   seq_scan_ctrl #(
      .DATA_W    (16),
      .PAT_W_MAX (8),
      .CNT_W     (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_pat      (cfg_pat),
      .cfg_len      (cfg_len),
      .cfg_overlap  (cfg_overlap),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_count    (out_count),
      .out_last_pos (out_last_pos),
      .hit          (hit),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: offer one word, record hit pulses per scan index and the out_valid latency.
   task automatic scan_word(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                            input logic [15:0] data, output logic [15:0] hmask, output int lat,
                            output logic [2:0] cnt, output logic [3:0] pos);
      cfg_pat     = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      in_data     = data;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      hmask    = '0;
      lat      = -1;
      for (int j = 1; j <= 40; j++) begin
         tick();
         if (j <= 16) hmask[j-1] = hit;
         if (out_valid) begin
            lat = j;
            break;
         end
      end
      cnt = out_count;
      pos = out_last_pos;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks += 6;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (out_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", out_count); end
      if (out_last_pos !== 4'd0) begin failures++; $display("FAIL reset_last_pos got=%0d exp=0", out_last_pos); end
      if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_overlap();
      logic [15:0] hm; int lat; logic [2:0] c; logic [3:0] p;
      scan_word(8'h05, 4'd3, 1'b1, 16'hAAAA, hm, lat, c, p);
      checks += 5;
      if (lat !== 17) begin failures++; $display("FAIL ovl_latency got=%0d exp=17", lat); end
      if (c !== 3'd7) begin failures++; $display("FAIL ovl_count got=%0d exp=7", c); end
      if (p !== 4'd14) begin failures++; $display("FAIL ovl_last_pos got=%0d exp=14", p); end
      if (hm !== 16'h5554) begin failures++; $display("FAIL ovl_hits got=%h exp=5554", hm); end
      if (busy !== 1'b1) begin failures++; $display("FAIL ovl_busy_report got=%b exp=1", busy); end
      handshake();
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL ovl_valid_drop got=%b exp=0", out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL ovl_ready_back got=%b exp=1", in_ready); end
      if (busy !== 1'b0) begin failures++; $display("FAIL ovl_busy_idle got=%b exp=0", busy); end
   endtask

   task automatic test_non_overlap();
      logic [15:0] hm; int lat; logic [2:0] c; logic [3:0] p;
      scan_word(8'h05, 4'd3, 1'b0, 16'hAAAA, hm, lat, c, p);
      checks += 4;
      if (lat !== 17) begin failures++; $display("FAIL novl_latency got=%0d exp=17", lat); end
      if (c !== 3'd4) begin failures++; $display("FAIL novl_count got=%0d exp=4", c); end
      if (p !== 4'd14) begin failures++; $display("FAIL novl_last_pos got=%0d exp=14", p); end
      if (hm !== 16'h4444) begin failures++; $display("FAIL novl_hits got=%h exp=4444", hm); end
      handshake();
   endtask

   task automatic test_a5a5();
      logic [15:0] hm; int lat; logic [2:0] c; logic [3:0] p;
      scan_word(8'h05, 4'd3, 1'b1, 16'hA5A5, hm, lat, c, p);
      checks += 3;
      if (c !== 3'd4) begin failures++; $display("FAIL a5a5_count got=%0d exp=4", c); end
      if (p !== 4'd15) begin failures++; $display("FAIL a5a5_last_pos got=%0d exp=15", p); end
      if (hm !== 16'h8484) begin failures++; $display("FAIL a5a5_hits got=%h exp=8484", hm); end
      handshake();
   endtask

   task automatic test_saturate_len();
      logic [15:0] hm; int lat; logic [2:0] c; logic [3:0] p;
      scan_word(8'h01, 4'd1, 1'b1, 16'hFFFF, hm, lat, c, p);
      checks += 3;
      if (c !== 3'd7) begin failures++; $display("FAIL sat_count got=%0d exp=7", c); end
      if (p !== 4'd15) begin failures++; $display("FAIL sat_last_pos got=%0d exp=15", p); end
      if (hm !== 16'hFFFF) begin failures++; $display("FAIL sat_hits got=%h exp=ffff", hm); end
      handshake();
      scan_word(8'h01, 4'd0, 1'b1, 16'hFFFF, hm, lat, c, p);
      checks += 3;
      if (c !== 3'd7) begin failures++; $display("FAIL len0_count got=%0d exp=7", c); end
      if (p !== 4'd15) begin failures++; $display("FAIL len0_last_pos got=%0d exp=15", p); end
      if (hm !== 16'hFFFF) begin failures++; $display("FAIL len0_hits got=%h exp=ffff", hm); end
      handshake();
      // len 12 clamps to 8: 10101010 completes at k=7,9,11,13,15.
      scan_word(8'hAA, 4'd12, 1'b1, 16'hAAAA, hm, lat, c, p);
      checks += 3;
      if (c !== 3'd5) begin failures++; $display("FAIL clamp_count got=%0d exp=5", c); end
      if (p !== 4'd15) begin failures++; $display("FAIL clamp_last_pos got=%0d exp=15", p); end
      if (hm !== 16'hAA80) begin failures++; $display("FAIL clamp_hits got=%h exp=aa80", hm); end
      handshake();
   endtask

   task automatic test_backpressure();
      logic [15:0] hm; int lat; logic [2:0] c; logic [3:0] p;
      scan_word(8'h05, 4'd3, 1'b1, 16'hA5A5, hm, lat, c, p);
      cfg_pat     = 8'h01;
      cfg_len     = 4'd1;
      cfg_overlap = 1'b1;
      in_data     = 16'hFFFF;
      in_valid    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks += 4;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, out_valid); end
         if (out_count !== 3'd4) begin failures++; $display("FAIL bp_count cyc=%0d got=%0d exp=4", i, out_count); end
         if (out_last_pos !== 4'd15) begin failures++; $display("FAIL bp_last_pos cyc=%0d got=%0d exp=15", i, out_last_pos); end
         if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_hs_valid got=%b exp=0", out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_hs_ready got=%b exp=1", in_ready); end
      if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_bypass busy=%b exp=0", busy); end
      tick();
      in_valid = 1'b0;
      checks += 2;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept_ready got=%b exp=0", in_ready); end
      if (busy !== 1'b1) begin failures++; $display("FAIL bp_accept_busy got=%b exp=1", busy); end
      lat = -1;
      for (int j = 1; j <= 40; j++) begin
         tick();
         if (out_valid) begin
            lat = j;
            break;
         end
      end
      checks += 3;
      if (lat !== 17) begin failures++; $display("FAIL bp_second_latency got=%0d exp=17", lat); end
      if (out_count !== 3'd7) begin failures++; $display("FAIL bp_second_count got=%0d exp=7", out_count); end
      if (out_last_pos !== 4'd15) begin failures++; $display("FAIL bp_second_pos got=%0d exp=15", out_last_pos); end
      handshake();
   endtask

   task automatic test_reset_mid_scan();
      logic [15:0] hm; int lat; logic [2:0] c; logic [3:0] p;
      cfg_pat     = 8'h01;
      cfg_len     = 4'd1;
      cfg_overlap = 1'b1;
      in_data     = 16'hFFFF;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks += 5;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
      if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      if (out_count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", out_count); end
      if (hit !== 1'b0) begin failures++; $display("FAIL rstmid_hit got=%b exp=0", hit); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      scan_word(8'h03, 4'd2, 1'b1, 16'h0000, hm, lat, c, p);
      checks += 4;
      if (lat !== 17) begin failures++; $display("FAIL zero_latency got=%0d exp=17", lat); end
      if (c !== 3'd0) begin failures++; $display("FAIL zero_count got=%0d exp=0", c); end
      if (p !== 4'd0) begin failures++; $display("FAIL zero_last_pos got=%0d exp=0", p); end
      if (hm !== 16'h0000) begin failures++; $display("FAIL zero_hits got=%h exp=0000", hm); end
      handshake();
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_non_overlap();
      test_a5a5();
      test_saturate_len();
      test_backpressure();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
